// File: rtl/gsim_pkg.sv
// Shared types and constants for the Gauss-Seidel iteration controller.
package gsim_pkg;

  localparam int N_ROW  = 16;
  localparam int IDX_W  = 4;
  localparam int ITER_W = 8;
  localparam int B_W    = 16;
  localparam int FRAC   = 16;
  localparam int X_W    = 16 + FRAC;

  localparam logic [X_W-1:0] CONV_TH_DEF = 32'h0000_0010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_SWEEP_END,
    S_DRAIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/gsim_ctrl.sv
// Gauss-Seidel sweep sequencer: loads b, issues one row update at a time to an
// external datapath for N_ITER sweeps, then streams the x vector out.
// Optional early exit on convergence is built when GSIM_CONV_EN is defined.
//
// state     | meaning
// IDLE      | waiting for the first b beat of a new problem
// LOAD      | collecting the remaining 15 b beats
// ISSUE     | one-cycle dp_start for the current row
// WAIT      | row in flight, waiting for dp_done
// SWEEP_END | bump sweep count, decide on another sweep or drain
// DRAIN     | read x[0..15] back from x memory
// DONE      | last result beat on the output
module gsim_ctrl
  import gsim_pkg::*;
#(
  parameter int              N_ITER  = 64,
  parameter logic [X_W-1:0]  CONV_TH = CONV_TH_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              in_en_i,
  input  logic [B_W-1:0]    b_in_i,
  output logic              b_we_o,
  output logic [IDX_W-1:0]  b_waddr_o,
  output logic [B_W-1:0]    b_wdata_o,
  output logic              x_clr_o,
  output logic              dp_start_o,
  output logic [IDX_W-1:0]  dp_idx_o,
  output logic [ITER_W-1:0] dp_iter_o,
  input  logic              dp_done_i,
  input  logic [X_W-1:0]    dp_delta_i,
  output logic              x_rd_en_o,
  output logic [IDX_W-1:0]  x_rd_idx_o,
  input  logic [X_W-1:0]    x_rd_data_i,
  output logic              out_valid_o,
  output logic [X_W-1:0]    x_out_o,
  output logic              busy_o
);

  localparam logic [IDX_W-1:0]  LAST_ROW  = IDX_W'(N_ROW - 1);
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(N_ITER);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    load_cnt_q, load_cnt_d;
  logic [IDX_W-1:0]    row_q, row_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [IDX_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic                out_valid_q;
  logic                sweep_clr;
  logic                conv_hit;
  logic [ITER_W-1:0]   iter_inc;

  assign iter_inc = iter_q + 8'd1;

  // Next-state and strobe decode; strobes are suppressed while reset is held.
  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    row_d      = row_q;
    iter_d     = iter_q;
    rd_cnt_d   = rd_cnt_q;
    b_we_o     = 1'b0;
    b_waddr_o  = '0;
    x_clr_o    = 1'b0;
    dp_start_o = 1'b0;
    x_rd_en_o  = 1'b0;
    x_rd_idx_o = '0;
    sweep_clr  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_en_i) begin
          b_we_o     = 1'b1;
          x_clr_o    = 1'b1;
          load_cnt_d = 4'd1;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_en_i) begin
          b_we_o    = 1'b1;
          b_waddr_o = load_cnt_q;
          if (load_cnt_q == LAST_ROW) begin
            load_cnt_d = '0;
            row_d      = '0;
            iter_d     = '0;
            sweep_clr  = 1'b1;
            state_d    = S_ISSUE;
          end else begin
            load_cnt_d = load_cnt_q + 4'd1;
          end
        end
      end
      S_ISSUE: begin
        dp_start_o = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (dp_done_i) begin
          if (row_q == LAST_ROW) begin
            state_d = S_SWEEP_END;
          end else begin
            row_d   = row_q + 4'd1;
            state_d = S_ISSUE;
          end
        end
      end
      S_SWEEP_END: begin
        iter_d = iter_inc;
        if ((iter_inc == LAST_ITER) || conv_hit) begin
          rd_cnt_d = '0;
          state_d  = S_DRAIN;
        end else begin
          row_d     = '0;
          sweep_clr = 1'b1;
          state_d   = S_ISSUE;
        end
      end
      S_DRAIN: begin
        x_rd_en_o  = 1'b1;
        x_rd_idx_o = rd_cnt_q;
        rd_cnt_d   = rd_cnt_q + 4'd1;
        if (rd_cnt_q == LAST_ROW) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (reset_i) begin
      b_we_o     = 1'b0;
      x_clr_o    = 1'b0;
      dp_start_o = 1'b0;
      x_rd_en_o  = 1'b0;
    end
  end

  // State, counters and the one-cycle read-latency alignment of out_valid.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      load_cnt_q  <= '0;
      row_q       <= '0;
      iter_q      <= '0;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      row_q       <= row_d;
      iter_q      <= iter_d;
      rd_cnt_q    <= rd_cnt_d;
      out_valid_q <= x_rd_en_o;
    end
  end

`ifdef GSIM_CONV_EN
  logic [X_W-1:0] max_q, max_d;

  // Track the largest row delta seen in the current sweep.
  always_comb begin
    max_d = max_q;
    if (sweep_clr) begin
      max_d = '0;
    end else if ((state_q == S_WAIT) && dp_done_i && (dp_delta_i > max_q)) begin
      max_d = dp_delta_i;
    end
  end

  // Per-sweep maximum register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      max_q <= '0;
    end else begin
      max_q <= max_d;
    end
  end

  // Sweep 0 has no prior solution to compare against, so it never exits early.
  assign conv_hit = (iter_q >= 8'd1) && (max_q < CONV_TH);
`else
  logic unused_conv;
  assign unused_conv = ^{dp_delta_i, CONV_TH, sweep_clr};
  assign conv_hit    = 1'b0;
`endif

  assign b_wdata_o   = b_we_o ? b_in_i : '0;
  assign dp_idx_o    = row_q;
  assign dp_iter_o   = iter_q;
  assign out_valid_o = out_valid_q;
  assign x_out_o     = out_valid_q ? x_rd_data_i : '0;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_gsim_ctrl.sv
// Self-checking bench for gsim_ctrl with a fixed-latency datapath model and
// an x memory model returning x[i] = i << 16.
module tb_gsim_ctrl;
  import gsim_pkg::*;

  localparam int N_IT = 4;
  localparam int LAT  = 3;
`ifdef GSIM_CONV_EN
  localparam int EXP_SWEEPS = 2;
`else
  localparam int EXP_SWEEPS = N_IT;
`endif
  localparam int RST_SWEEP = (EXP_SWEEPS > 2) ? 2 : 1;

  logic        clk;
  logic        reset;
  logic        in_en;
  logic [15:0] b_in;
  logic        b_we;
  logic [3:0]  b_waddr;
  logic [15:0] b_wdata;
  logic        x_clr;
  logic        dp_start;
  logic [3:0]  dp_idx;
  logic [7:0]  dp_iter;
  logic        dp_done;
  logic [31:0] dp_delta;
  logic        x_rd_en;
  logic [3:0]  x_rd_idx;
  logic [31:0] x_rd_data;
  logic        out_valid;
  logic [31:0] x_out;
  logic        busy;

  gsim_ctrl #(.N_ITER(N_IT)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .in_en_i     (in_en),
    .b_in_i      (b_in),
    .b_we_o      (b_we),
    .b_waddr_o   (b_waddr),
    .b_wdata_o   (b_wdata),
    .x_clr_o     (x_clr),
    .dp_start_o  (dp_start),
    .dp_idx_o    (dp_idx),
    .dp_iter_o   (dp_iter),
    .dp_done_i   (dp_done),
    .dp_delta_i  (dp_delta),
    .x_rd_en_o   (x_rd_en),
    .x_rd_idx_o  (x_rd_idx),
    .x_rd_data_i (x_rd_data),
    .out_valid_o (out_valid),
    .x_out_o     (x_out),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [19:0] q_b[$];
  logic [11:0] q_dp[$];
  logic [31:0] q_out[$];

  int n_bwr, n_start, n_out;
  int last_start_cyc, first_out_cyc, last_out_cyc;
  int dp_cnt = 0;
  logic [7:0] dp_it_cur = 8'd0;
  logic       xr_v = 1'b0;
  logic [3:0] xr_idx = 4'd0;

  // Datapath and x memory models: respond one posedge (+1) after what the
  // monitor captured on the preceding negedge.
  initial begin
    dp_done   = 1'b0;
    dp_delta  = 32'd0;
    x_rd_data = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk);
      #1;
      if (dp_cnt > 0) begin
        dp_cnt   = dp_cnt - 1;
        dp_done  = (dp_cnt == 0);
        dp_delta = (dp_it_cur == 8'd0) ? 32'h0010_0000 : 32'h0000_0005;
      end else begin
        dp_done  = 1'b0;
        dp_delta = 32'd0;
      end
      x_rd_data = xr_v ? ({28'd0, xr_idx} << 16) : 32'hDEAD_BEEF;
    end
  end

  // Monitor / scoreboard on the falling edge.
  initial begin
    logic [19:0] eb;
    logic [11:0] ed;
    logic [31:0] eo;
    int sp;
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (b_we) begin
        checks++;
        n_bwr++;
        if (q_b.size() == 0) begin
          errors++;
          $display("FAIL b_write_extra: got addr=%0d data=%h, required no write", b_waddr, b_wdata);
        end else begin
          eb = q_b.pop_front();
          if ({b_waddr, b_wdata} !== eb) begin
            errors++;
            $display("FAIL b_write: got addr=%0d data=%h, required addr=%0d data=%h", b_waddr, b_wdata, eb[19:16], eb[15:0]);
          end
        end
      end
      if (dp_start) begin
        checks++;
        if (dp_cnt > 0) begin
          errors++;
          $display("FAIL row_in_flight: dp_start with %0d cycles of previous row pending, required none", dp_cnt);
        end
        checks++;
        if (q_dp.size() == 0) begin
          errors++;
          $display("FAIL dp_start_extra: got iter=%0d idx=%0d, required no start", dp_iter, dp_idx);
        end else begin
          ed = q_dp.pop_front();
          if ({dp_iter, dp_idx} !== ed) begin
            errors++;
            $display("FAIL dp_start_order: got iter=%0d idx=%0d, required iter=%0d idx=%0d", dp_iter, dp_idx, ed[11:4], ed[3:0]);
          end
        end
        if (last_start_cyc >= 0) begin
          checks++;
          sp = (dp_idx == 4'd0) ? LAT + 2 : LAT + 1;
          if (cyc - last_start_cyc != sp) begin
            errors++;
            $display("FAIL dp_start_spacing: got %0d, required %0d (idx=%0d)", cyc - last_start_cyc, sp, dp_idx);
          end
        end
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_at_start: got %b, required 1", busy);
        end
        last_start_cyc = cyc;
        n_start++;
        dp_cnt    = LAT;
        dp_it_cur = dp_iter;
      end
      xr_v   = x_rd_en;
      xr_idx = x_rd_idx;
      checks++;
      if (out_valid) begin
        n_out++;
        if (first_out_cyc < 0) first_out_cyc = cyc;
        last_out_cyc = cyc;
        if (q_out.size() == 0) begin
          errors++;
          $display("FAIL out_extra: got x_out=%h, required no output", x_out);
        end else begin
          eo = q_out.pop_front();
          if (x_out !== eo) begin
            errors++;
            $display("FAIL x_out: got %h, required %h", x_out, eo);
          end
        end
      end else if (x_out !== 32'd0) begin
        errors++;
        $display("FAIL x_out_idle: got %h, required 0", x_out);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_stats;
    n_bwr = 0; n_start = 0; n_out = 0;
    last_start_cyc = -1; first_out_cyc = -1; last_out_cyc = -1;
  endtask

  task automatic push_run(input int sweeps, input logic [15:0] base);
    for (int i = 0; i < 16; i++) q_b.push_back({4'(i), 16'(base + 16'(i))});
    for (int s = 0; s < sweeps; s++)
      for (int r = 0; r < 16; r++) q_dp.push_back({8'(s), 4'(r)});
    for (int i = 0; i < 16; i++) q_out.push_back(32'(i) << 16);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_run_end(input bit ok, input string tag);
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_timeout: busy stuck high, required idle", tag); end
    checks++;
    if (n_bwr != 16) begin errors++; $display("FAIL %s_b_writes: got %0d, required 16", tag, n_bwr); end
    checks++;
    if (n_start != 16 * EXP_SWEEPS) begin errors++; $display("FAIL %s_starts: got %0d, required %0d", tag, n_start, 16 * EXP_SWEEPS); end
    checks++;
    if (n_out != 16 || last_out_cyc - first_out_cyc != 15) begin
      errors++;
      $display("FAIL %s_out_burst: got %0d beats over %0d cycles, required 16 over 16", tag, n_out, last_out_cyc - first_out_cyc + 1);
    end
    checks++;
    if (q_dp.size() != 0 || q_out.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover: got %0d/%0d/%0d pending, required 0", tag, q_b.size(), q_dp.size(), q_out.size());
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; in_en = 1'b0; b_in = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({b_we, x_clr, dp_start, x_rd_en, out_valid, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b, required 000000", {b_we, x_clr, dp_start, x_rd_en, out_valid, busy});
    end
    checks++;
    if ({dp_idx, dp_iter, b_waddr, x_rd_idx} !== 20'd0) begin
      errors++;
      $display("FAIL reset_fields: got %h, required 0", {dp_idx, dp_iter, b_waddr, x_rd_idx});
    end
    checks++;
    if (x_out !== 32'd0) begin errors++; $display("FAIL reset_x_out: got %h, required 0", x_out); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    bit ok;
    clear_stats();
    push_run(EXP_SWEEPS, 16'h0001);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      in_en = 1'b1;
      b_in  = 16'(i + 1);
      @(negedge clk);
      checks++;
      if (x_clr !== (i == 0)) begin
        errors++;
        $display("FAIL x_clr beat%0d: got %b, required %b", i, x_clr, (i == 0));
      end
    end
    @(posedge clk);
    #1;
    in_en = 1'b0;
    b_in  = 16'd0;
    @(negedge clk);
    checks++;
    if (dp_start !== 1'b1) begin errors++; $display("FAIL first_start_latency: got dp_start=%b, required 1", dp_start); end
    wait_idle(ok);
    check_run_end(ok, "basic");
  endtask

  task automatic test_gaps;
    bit ok;
    clear_stats();
    push_run(EXP_SWEEPS, 16'hA000);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      in_en = 1'b1; b_in = 16'hA000 + 16'(i);
      @(posedge clk); #1;
      in_en = 1'b0; b_in = 16'h5555;
    end
    for (int i = 0; i < 4; i++) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      in_en = 1'b1; b_in = 16'hBEEF;
      @(posedge clk); #1;
    end
    in_en = 1'b0; b_in = 16'd0;
    wait_idle(ok);
    check_run_end(ok, "gaps");
  endtask

  task automatic test_reset_midrun;
    bit ok;
    bit hit;
    clear_stats();
    push_run(EXP_SWEEPS, 16'h0100);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      in_en = 1'b1; b_in = 16'h0100 + 16'(i);
    end
    @(posedge clk); #1;
    in_en = 1'b0; b_in = 16'd0;
    hit = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (dp_start && dp_iter == 8'(RST_SWEEP) && dp_idx == 4'd5) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL midrun_reach: got no sweep %0d row 5 start, required one", RST_SWEEP); end
    @(posedge clk); #1;
    reset = 1'b1;
    q_dp.delete(); q_out.delete(); q_b.delete();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({b_we, x_clr, dp_start, x_rd_en, out_valid, busy} !== 6'b0) begin
      errors++;
      $display("FAIL midrun_reset_strobes: got %b, required 000000", {b_we, x_clr, dp_start, x_rd_en, out_valid, busy});
    end
    checks++;
    if ({dp_idx, dp_iter, b_waddr, x_rd_idx, x_out} !== 52'd0) begin
      errors++;
      $display("FAIL midrun_reset_fields: got %h, required 0", {dp_idx, dp_iter, b_waddr, x_rd_idx, x_out});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    clear_stats();
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || n_start != 0 || n_out != 0) begin
      errors++;
      $display("FAIL midrun_quiet: got busy=%b starts=%0d outs=%0d, required 0/0/0", busy, n_start, n_out);
    end
    clear_stats();
    push_run(EXP_SWEEPS, 16'h0200);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      in_en = 1'b1; b_in = 16'h0200 + 16'(i);
    end
    @(posedge clk); #1;
    in_en = 1'b0; b_in = 16'd0;
    wait_idle(ok);
    check_run_end(ok, "reload");
  endtask

  task automatic test_back_to_back;
    bit ok;
    clear_stats();
    push_run(EXP_SWEEPS, 16'h0300);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      in_en = 1'b1; b_in = 16'h0300 + 16'(i);
    end
    @(posedge clk); #1;
    in_en = 1'b0; b_in = 16'd0;
    wait_idle(ok);
    check_run_end(ok, "b2b");
  endtask

  initial begin
    reset = 1'b1;
    in_en = 1'b0;
    b_in  = 16'd0;
    clear_stats();
    test_reset();
    test_basic();
    test_gaps();
    test_reset_midrun();
    test_back_to_back();
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
